// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe controller: cell codes, FSM states,
// winning-line masks and cursor helpers.
package ttt_pkg;

  localparam int BOARD_W = 18;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_P1    = 2'b01,
    CELL_P2    = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    PLAY,
    CHECK,
    WIN,
    DRAW
  } state_t;

  // Index 0..7: rows 0-2, columns 0-2, main diagonal, anti-diagonal (cells row-major)
  localparam logic [7:0][8:0] WIN_LINES = {
    9'h054, 9'h111, 9'h124, 9'h092, 9'h049, 9'h1C0, 9'h038, 9'h007
  };

  function automatic logic [1:0] col_of(input logic [3:0] pos);
    case (pos)
      4'd0, 4'd3, 4'd6: col_of = 2'd0;
      4'd1, 4'd4, 4'd7: col_of = 2'd1;
      default:          col_of = 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/ttt_win_detect.sv
// Combinational line checker: returns the OR of every winning line fully
// occupied by the given mark (zero means no win).
module ttt_win_detect import ttt_pkg::*; (
  input  logic [BOARD_W-1:0] board,
  input  logic [1:0]         mark,
  output logic [8:0]         win_mask
);

  logic [8:0]      owned;
  logic [7:0][8:0] line_hit;

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_cell
      assign owned[gi] = (board[2*gi +: 2] == mark) && (mark != CELL_EMPTY);
    end
    for (gi = 0; gi < 8; gi++) begin : g_line
      assign line_hit[gi] = ((owned & WIN_LINES[gi]) == WIN_LINES[gi]) ? WIN_LINES[gi] : 9'h000;
    end
  endgenerate

  always_comb begin
    win_mask = 9'h000;
    for (int i = 0; i < 8; i++) begin
      win_mask = win_mask | line_hit[i];
    end
  end

endmodule

// File: rtl/ttt_board_ctrl.sv
// Tic-tac-toe game controller: cursor, turn order, move legality, win/draw
// detection and win-line blinking, feeding the VGA renderer.
module ttt_board_ctrl import ttt_pkg::*; #(
  parameter int BLINK_DIV  = 12_500_000,
  parameter int START_CELL = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_place,
  input  logic               btn_restart,
  output logic [BOARD_W-1:0] board,
  output logic [8:0]         cell_select,
  output logic               cur_player,
  output logic               game_over,
  output logic [1:0]         winner
);

  localparam int               CNT_W     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(BLINK_DIV - 1);
  localparam logic [3:0]       START_POS = 4'(START_CELL);
  localparam logic [8:0]       START_SEL = 9'(1) << START_CELL;

  state_t             state_reg, state_next;
  logic [BOARD_W-1:0] board_reg, board_next;
  logic [3:0]         cursor_reg, cursor_next;
  logic [8:0]         cell_select_reg, cell_select_next;
  logic [8:0]         win_mask_reg, win_mask_next;
  logic               cur_player_reg, cur_player_next;
  logic               game_over_reg, game_over_next;
  logic [1:0]         winner_reg, winner_next;
  logic [3:0]         move_cnt_reg, move_cnt_next;
  logic [CNT_W-1:0]   blink_cnt_reg, blink_cnt_next;
  logic               phase_reg, phase_next;

  logic [1:0] mark;
  logic [4:0] cell_idx;
  logic [1:0] cell_at_cursor;
  logic [8:0] line_mask;

  assign mark           = cur_player_reg ? CELL_P2 : CELL_P1;
  assign cell_idx       = {cursor_reg, 1'b0};
  assign cell_at_cursor = board_reg[cell_idx +: 2];

  // Evaluated against the registered board, so CHECK sees the mark placed the cycle before
  ttt_win_detect u_win_detect (
    .board    (board_reg),
    .mark     (mark),
    .win_mask (line_mask)
  );

  always_comb begin
    state_next       = state_reg;
    board_next       = board_reg;
    cursor_next      = cursor_reg;
    win_mask_next    = win_mask_reg;
    cur_player_next  = cur_player_reg;
    game_over_next   = game_over_reg;
    winner_next      = winner_reg;
    move_cnt_next    = move_cnt_reg;
    blink_cnt_next   = blink_cnt_reg;
    phase_next       = phase_reg;
    cell_select_next = cell_select_reg;

    if (btn_restart) begin
      state_next      = PLAY;
      board_next      = '0;
      cursor_next     = START_POS;
      win_mask_next   = 9'h000;
      cur_player_next = 1'b0;
      game_over_next  = 1'b0;
      winner_next     = CELL_EMPTY;
      move_cnt_next   = 4'd0;
      blink_cnt_next  = '0;
      phase_next      = 1'b0;
    end else begin
      case (state_reg)
        PLAY: begin
          if (btn_place) begin
            if (cell_at_cursor == CELL_EMPTY) begin
              board_next[cell_idx +: 2] = mark;
              if (move_cnt_reg < 4'd9) move_cnt_next = move_cnt_reg + 4'd1;
              state_next = CHECK;
            end
          end else if (btn_up) begin
            cursor_next = (cursor_reg >= 4'd3) ? cursor_reg - 4'd3 : cursor_reg + 4'd6;
          end else if (btn_down) begin
            cursor_next = (cursor_reg <= 4'd5) ? cursor_reg + 4'd3 : cursor_reg - 4'd6;
          end else if (btn_left) begin
            cursor_next = (col_of(cursor_reg) == 2'd0) ? cursor_reg + 4'd2 : cursor_reg - 4'd1;
          end else if (btn_right) begin
            cursor_next = (col_of(cursor_reg) == 2'd2) ? cursor_reg - 4'd2 : cursor_reg + 4'd1;
          end
        end
        CHECK: begin
          if (|line_mask) begin
            state_next     = WIN;
            game_over_next = 1'b1;
            winner_next    = mark;
            win_mask_next  = line_mask;
            phase_next     = 1'b1;
            blink_cnt_next = '0;
          end else if (move_cnt_reg == 4'd9) begin
            state_next     = DRAW;
            game_over_next = 1'b1;
            winner_next    = CELL_EMPTY;
          end else begin
            cur_player_next = ~cur_player_reg;
            state_next      = PLAY;
          end
        end
        WIN: begin
          if (blink_cnt_reg == CNT_MAX) begin
            blink_cnt_next = '0;
            phase_next     = ~phase_reg;
          end else begin
            blink_cnt_next = blink_cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Highlight is derived from next-state values so the output stays registered
    case (state_next)
      WIN:     cell_select_next = phase_next ? win_mask_next : 9'h000;
      DRAW:    cell_select_next = 9'h000;
      default: cell_select_next = 9'(1) << cursor_next;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= PLAY;
      board_reg       <= '0;
      cursor_reg      <= START_POS;
      cell_select_reg <= START_SEL;
      win_mask_reg    <= 9'h000;
      cur_player_reg  <= 1'b0;
      game_over_reg   <= 1'b0;
      winner_reg      <= 2'b00;
      move_cnt_reg    <= 4'd0;
      blink_cnt_reg   <= '0;
      phase_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      board_reg       <= board_next;
      cursor_reg      <= cursor_next;
      cell_select_reg <= cell_select_next;
      win_mask_reg    <= win_mask_next;
      cur_player_reg  <= cur_player_next;
      game_over_reg   <= game_over_next;
      winner_reg      <= winner_next;
      move_cnt_reg    <= move_cnt_next;
      blink_cnt_reg   <= blink_cnt_next;
      phase_reg       <= phase_next;
    end
  end

  assign board       = board_reg;
  assign cell_select = cell_select_reg;
  assign cur_player  = cur_player_reg;
  assign game_over   = game_over_reg;
  assign winner      = winner_reg;

endmodule

// File: tb/tb_ttt_board_ctrl.sv
// Directed bench for ttt_board_ctrl: cursor wrap, win with blink, illegal
// place, draw, restart and async reset mid-move.
module tb_ttt_board_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        btn_up, btn_down, btn_left, btn_right, btn_place, btn_restart;
  logic [17:0] board;
  logic [8:0]  cell_select;
  logic        cur_player, game_over;
  logic [1:0]  winner;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [5:0] U  = 6'b000001;
  localparam logic [5:0] D  = 6'b000010;
  localparam logic [5:0] L  = 6'b000100;
  localparam logic [5:0] R  = 6'b001000;
  localparam logic [5:0] P  = 6'b010000;
  localparam logic [5:0] RS = 6'b100000;

  ttt_board_ctrl #(.BLINK_DIV(4), .START_CELL(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_place   (btn_place),
    .btn_restart (btn_restart),
    .board       (board),
    .cell_select (cell_select),
    .cur_player  (cur_player),
    .game_over   (game_over),
    .winner      (winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [17:0] b, input logic [8:0] cs,
                         input logic cp, input logic go, input logic [1:0] w);
    chk({tag, ".board"}, 32'(board), 32'(b));
    chk({tag, ".cell_select"}, 32'(cell_select), 32'(cs));
    chk({tag, ".cur_player"}, 32'(cur_player), 32'(cp));
    chk({tag, ".game_over"}, 32'(game_over), 32'(go));
    chk({tag, ".winner"}, 32'(winner), 32'(w));
  endtask

  // Called at a negedge; holds the buttons across one posedge, returns at the next negedge
  task automatic press(input logic [5:0] b);
    {btn_restart, btn_place, btn_right, btn_left, btn_down, btn_up} = b;
    @(negedge clk);
    {btn_restart, btn_place, btn_right, btn_left, btn_down, btn_up} = 6'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    {btn_restart, btn_place, btn_right, btn_left, btn_down, btn_up} = 6'b0;
    idle(2);
    chk_all("in_reset", 18'h0, 9'h010, 1'b0, 1'b0, 2'b00);
    reset_n = 1'b1;
    idle(1);
    chk_all("after_reset", 18'h0, 9'h010, 1'b0, 1'b0, 2'b00);

    // Cursor movement and wrap
    press(R);       chk("right_4to5", 32'(cell_select), 32'h020);
    press(R);       chk("right_wrap", 32'(cell_select), 32'h008);
    press(U);       chk("up_3to0", 32'(cell_select), 32'h001);
    press(U);       chk("up_wrap", 32'(cell_select), 32'h040);
    press(U|D|L|R); chk("dir_priority", 32'(cell_select), 32'h008);
    press(L);       chk("left_wrap", 32'(cell_select), 32'h020);
    press(D);       chk("down_5to8", 32'(cell_select), 32'h100);
    press(D);       chk("down_wrap", 32'(cell_select), 32'h004);
    press(RS);      chk_all("restart1", 18'h0, 9'h010, 1'b0, 1'b0, 2'b00);

    // P1 takes row 0, P2 at cells 3 and 4
    press(U); press(L); press(P);
    chk("p1_c0_board", 32'(board), 32'h00001);
    idle(1); chk("turn_to_p2", 32'(cur_player), 32'h1);
    press(D); press(P); idle(1);
    chk("p2_c3_board", 32'(board), 32'h00081);
    chk("turn_to_p1", 32'(cur_player), 32'h0);
    press(U); press(R); press(P); idle(1);
    chk("p1_c1_board", 32'(board), 32'h00085);
    press(D); press(P); idle(1);
    chk("p2_c4_board", 32'(board), 32'h00285);
    press(U); press(R); press(P);
    chk("check_not_over", 32'(game_over), 32'h0);
    idle(1);
    chk_all("win_row0", 18'h00295, 9'h007, 1'b0, 1'b1, 2'b01);
    idle(3); chk("blink_on_hold", 32'(cell_select), 32'h007);
    idle(1); chk("blink_off", 32'(cell_select), 32'h000);
    idle(3); chk("blink_off_hold", 32'(cell_select), 32'h000);
    idle(1); chk("blink_on", 32'(cell_select), 32'h007);
    press(P); chk("win_place_ignored", 32'(board), 32'h00295);

    // Place twice on the same cell
    press(RS); chk_all("restart2", 18'h0, 9'h010, 1'b0, 1'b0, 2'b00);
    press(P); idle(1);
    chk("first_place", 32'(board), 32'h00100);
    chk("first_turn", 32'(cur_player), 32'h1);
    press(P); chk("occupied_board", 32'(board), 32'h00100);
    idle(1);  chk("occupied_turn", 32'(cur_player), 32'h1);

    // Draw: X,O,X / X,O,O / O,X,X
    press(RS);
    press(U); press(L); press(P); idle(1);
    press(R); press(P); idle(1);
    press(R); press(P); idle(1);
    press(D); press(L); press(P); idle(1);
    press(L); press(P); idle(1);
    press(L); press(P); idle(1);
    press(D); press(L); press(P); idle(1);
    press(L); press(P); idle(1);
    press(L); press(P); idle(1);
    chk_all("draw", 18'h16A59, 9'h000, 1'b0, 1'b1, 2'b00);
    press(P); chk("draw_place_ignored", 32'(board), 32'h16A59);

    // Restart with place in the same cycle
    press(RS); press(P); idle(1);
    press(R);
    press(P|RS);
    chk_all("restart_with_place", 18'h0, 9'h010, 1'b0, 1'b0, 2'b00);

    // Async reset while in CHECK
    press(P);
    chk("check_entered", 32'(board), 32'h00100);
    reset_n = 1'b0;
    #1;
    chk_all("reset_in_check", 18'h0, 9'h010, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    reset_n = 1'b1;
    idle(1);
    chk_all("after_reset_check", 18'h0, 9'h010, 1'b0, 1'b0, 2'b00);
    press(P); idle(1);
    chk("play_after_reset", 32'(board), 32'h00100);
    chk("play_turn_after_reset", 32'(cur_player), 32'h1);

    // Restart while in CHECK
    press(R); press(P);
    press(RS);
    chk_all("restart_in_check", 18'h0, 9'h010, 1'b0, 1'b0, 2'b00);
    idle(1);
    chk("restart_check_stays", 32'(cur_player), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
